// File: rtl/ama_riscv_load_align_unit_pkg.sv
// rtl/ama_riscv_load_align_unit_pkg.sv - size codes and FSM states for the load align unit
package ama_riscv_load_align_unit_pkg;

  // funct3[1:0] size codes
  localparam logic [1:0] DMEM_BYTE   = 2'd0;
  localparam logic [1:0] DMEM_HALF   = 2'd1;
  localparam logic [1:0] DMEM_WORD   = 2'd2;
  localparam logic [1:0] DMEM_DOUBLE = 2'd3;

  typedef enum logic [2:0] {
    LAU_IDLE   = 3'd0,
    LAU_ISSUE0 = 3'd1,
    LAU_WAIT0  = 3'd2,
    LAU_ISSUE1 = 3'd3,
    LAU_WAIT1  = 3'd4,
    LAU_RESP   = 3'd5
  } lau_state_t;

endpackage

// File: rtl/ama_riscv_load_extract.sv
// rtl/ama_riscv_load_extract.sv - window shift, byte mask and sign/zero extension of load data
module ama_riscv_load_extract
  import ama_riscv_load_align_unit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int OW  = $clog2(NB)
) (
  input  logic [2*XLEN-1:0] window,
  input  logic [OW-1:0]     off,
  input  logic [2:0]        width,
  output logic [XLEN-1:0]   data
);

  logic [2*XLEN-1:0] shifted;
  logic [XLEN-1:0]   mask;
  logic              msb;

  // byte offset selects the start of the field inside the two-beat window
  assign shifted = window >> {off, 3'b000};

  // keep the low field bytes, then fill the rest with the field MSB for signed loads
  always_comb begin
    mask = '1;
    msb  = shifted[2*XLEN-1];
    case (width[1:0])
      DMEM_BYTE: begin
        mask = XLEN'(8'hFF);
        msb  = shifted[7];
      end
      DMEM_HALF: begin
        mask = XLEN'(16'hFFFF);
        msb  = shifted[15];
      end
      DMEM_WORD: begin
        mask = XLEN'(32'hFFFF_FFFF);
        msb  = shifted[31];
      end
      default: begin
        mask = '1;
        msb  = shifted[XLEN-1];
      end
    endcase
    data = (shifted[XLEN-1:0] & mask) | ((msb && !width[2]) ? ~mask : '0);
  end

endmodule

// File: rtl/ama_riscv_load_align_unit.sv
// rtl/ama_riscv_load_align_unit.sv - load alignment FSM issuing one or two aligned memory beats
module ama_riscv_load_align_unit
  import ama_riscv_load_align_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int AW               = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [2:0]      req_width,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_misaligned,
  output logic            rsp_illegal
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lau_state_t        state;
  logic [OW-1:0]     off_q;
  logic [2:0]        width_q;
  logic              cross_q;
  logic [XLEN-1:0]   beat0_q;

  logic [OW-1:0]     off_in;
  logic              cross_in;
  logic              illegal_in;
  logic [XLEN-1:0]   beat0_sel;
  logic [XLEN-1:0]   beat1_sel;
  logic [XLEN-1:0]   ext_data;

  // classify the incoming request: byte offset, boundary crossing, unsupported size
  always_comb begin
    off_in     = req_addr[OW-1:0];
    cross_in   = (int'(off_in) + (1 << req_width[1:0])) > NB;
    illegal_in = (req_width[1:0] == DMEM_DOUBLE) && (XLEN == 32);
  end

  // the beat arriving this cycle feeds the extractor directly so the response registers on arrival
  always_comb begin
    beat0_sel = (state == LAU_WAIT0) ? mem_rsp_data : beat0_q;
    beat1_sel = (state == LAU_WAIT1) ? mem_rsp_data : '0;
  end

  ama_riscv_load_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .window (({beat1_sel, beat0_sel})),
    .off    (off_q),
    .width  (width_q),
    .data   (ext_data)
  );

  // request/beat sequencing with all handshake and response outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LAU_IDLE;
      req_ready      <= 1'b1;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
      off_q          <= '0;
      width_q        <= '0;
      cross_q        <= 1'b0;
      beat0_q        <= '0;
    end else begin
      case (state)
        LAU_IDLE: begin
          if (req_valid) begin
            off_q     <= off_in;
            width_q   <= req_width;
            cross_q   <= cross_in;
            req_ready <= 1'b0;
            if (illegal_in) begin
              rsp_illegal <= 1'b1;
              rsp_valid   <= 1'b1;
              state       <= LAU_RESP;
            end else if (cross_in && (SPLIT_MISALIGNED == 0)) begin
              rsp_misaligned <= 1'b1;
              rsp_valid      <= 1'b1;
              state          <= LAU_RESP;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
              state         <= LAU_ISSUE0;
            end
          end
        end
        LAU_ISSUE0: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= LAU_WAIT0;
          end
        end
        LAU_WAIT0: begin
          if (mem_rsp_valid) begin
            beat0_q <= mem_rsp_data;
            if (cross_q) begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= mem_req_addr + AW'(NB);
              state         <= LAU_ISSUE1;
            end else begin
              rsp_data  <= ext_data;
              rsp_valid <= 1'b1;
              state     <= LAU_RESP;
            end
          end
        end
        LAU_ISSUE1: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= LAU_WAIT1;
          end
        end
        LAU_WAIT1: begin
          if (mem_rsp_valid) begin
            rsp_data  <= ext_data;
            rsp_valid <= 1'b1;
            state     <= LAU_RESP;
          end
        end
        LAU_RESP: begin
          rsp_valid      <= 1'b0;
          rsp_misaligned <= 1'b0;
          rsp_illegal    <= 1'b0;
          req_ready      <= 1'b1;
          state          <= LAU_IDLE;
        end
        default: begin
          mem_req_valid <= 1'b0;
          rsp_valid     <= 1'b0;
          req_ready     <= 1'b1;
          state         <= LAU_IDLE;
        end
      endcase
    end
  end

endmodule
